// File: rtl/multicycle_ctrl_if.sv
// Control interface for the multicycle ARMv3 controller: IR fields and condition in, datapath strobes out.
// MemReady only exists when MEM_WAIT_EN is defined.
interface multicycle_ctrl_if #(parameter int STATE_W = 4);
  logic [1:0]         Op;
  logic [5:0]         Funct;
  logic [3:0]         Rd;
  logic               NoWrite;
  logic               CondEx;
`ifdef MEM_WAIT_EN
  logic               MemReady;
`endif
  logic               MemReq;
  logic               AdrSrc;
  logic               IRWrite;
  logic               PCWrite;
  logic               RegW;
  logic               MemW;
  logic               ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic               ALUOp;
  logic [1:0]         ResultSrc;
  logic               InstrDone;
  logic               Undef;
  logic [STATE_W-1:0] State;

  modport master (
    output Op, Funct, Rd, NoWrite, CondEx,
`ifdef MEM_WAIT_EN
    output MemReady,
`endif
    input  MemReq, AdrSrc, IRWrite, PCWrite, RegW, MemW, ALUSrcA, ALUSrcB,
    input  ALUOp, ResultSrc, InstrDone, Undef, State
  );

  modport slave (
    input  Op, Funct, Rd, NoWrite, CondEx,
`ifdef MEM_WAIT_EN
    input  MemReady,
`endif
    output MemReq, AdrSrc, IRWrite, PCWrite, RegW, MemW, ALUSrcA, ALUSrcB,
    output ALUOp, ResultSrc, InstrDone, Undef, State
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main sequencing FSM of the multicycle ARMv3 core (DP reg/imm, LDR/STR imm, B).
// Define MEM_WAIT_EN to add MemReady wait states in FETCH, MEMRD and MEMWR.
//
// state  | meaning
// FETCH  | read instruction at PC, load IR, PC <= PC+4
// DECODE | decode IR, ALU computes PC+8
// MEMADR | ALU computes Rn + imm for load/store
// MEMRD  | read data memory at ALUResult
// MEMWB  | write loaded data to Rd (or PC)
// MEMWR  | write data memory at ALUResult
// EXECR  | DP with register operand B
// EXECI  | DP with immediate operand B
// ALUWB  | write ALU result to Rd (or PC)
// BRANCH | PC <= PC+8 + offset
module multicycle_ctrl #(
  parameter int STATE_W = 4
) (
  input logic           CLK,
  input logic           RESETn,
  multicycle_ctrl_if.slave bus
);

  typedef enum logic [STATE_W-1:0] {
    FETCH  = STATE_W'(0),
    DECODE = STATE_W'(1),
    MEMADR = STATE_W'(2),
    MEMRD  = STATE_W'(3),
    MEMWB  = STATE_W'(4),
    MEMWR  = STATE_W'(5),
    EXECR  = STATE_W'(6),
    EXECI  = STATE_W'(7),
    ALUWB  = STATE_W'(8),
    BRANCH = STATE_W'(9)
  } state_t;

  state_t     state, state_nxt;
  logic       mem_req, adr_src, ir_write, pc_write, reg_w, mem_w;
  logic       alu_src_a, alu_op, instr_done, undef, wb_en;
  logic [1:0] alu_src_b, result_src;
  logic       unused_funct;

  assign unused_funct = ^bus.Funct[4:1];

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) state <= FETCH;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt  = FETCH;
    mem_req    = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 1'b0;
    result_src = 2'b00;
    instr_done = 1'b0;
    undef      = 1'b0;
    wb_en      = 1'b0;
    case (state)
      FETCH: begin
        mem_req    = 1'b1;
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
`ifdef MEM_WAIT_EN
        ir_write   = bus.MemReady;
        pc_write   = bus.MemReady;
        state_nxt  = bus.MemReady ? DECODE : FETCH;
`else
        ir_write   = 1'b1;
        pc_write   = 1'b1;
        state_nxt  = DECODE;
`endif
      end
      DECODE: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        case (bus.Op)
          2'b00:   state_nxt = bus.Funct[5] ? EXECI : EXECR;
          2'b01:   state_nxt = MEMADR;
          2'b10:   state_nxt = BRANCH;
          default: begin
            state_nxt  = FETCH;
            undef      = 1'b1;
            instr_done = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        alu_src_b = 2'b01;
        state_nxt = bus.Funct[0] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        mem_req   = 1'b1;
        adr_src   = 1'b1;
`ifdef MEM_WAIT_EN
        state_nxt = bus.MemReady ? MEMWB : MEMRD;
`else
        state_nxt = MEMWB;
`endif
      end
      MEMWB: begin
        result_src = 2'b01;
        instr_done = 1'b1;
        wb_en      = bus.CondEx;   // loads ignore NoWrite
      end
      MEMWR: begin
        mem_req    = 1'b1;
        adr_src    = 1'b1;
`ifdef MEM_WAIT_EN
        mem_w      = bus.CondEx & bus.MemReady;
        instr_done = bus.MemReady;
        state_nxt  = bus.MemReady ? FETCH : MEMWR;
`else
        mem_w      = bus.CondEx;
        instr_done = 1'b1;
`endif
      end
      EXECR: begin
        alu_op    = 1'b1;
        state_nxt = ALUWB;
      end
      EXECI: begin
        alu_op    = 1'b1;
        alu_src_b = 2'b01;
        state_nxt = ALUWB;
      end
      ALUWB: begin
        instr_done = 1'b1;
        wb_en      = bus.CondEx & ~bus.NoWrite;
      end
      BRANCH: begin
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        pc_write   = bus.CondEx;
        instr_done = 1'b1;
      end
      default: state_nxt = FETCH;
    endcase
    // Writeback to R15 is a PC load, never a register-file write
    if (bus.Rd == 4'hF) pc_write = pc_write | wb_en;
    else                reg_w    = wb_en;
    if (!RESETn) begin
      mem_req    = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_w      = 1'b0;
      mem_w      = 1'b0;
      instr_done = 1'b0;
      undef      = 1'b0;
    end
  end

  assign bus.MemReq    = mem_req;
  assign bus.AdrSrc    = adr_src;
  assign bus.IRWrite   = ir_write;
  assign bus.PCWrite   = pc_write;
  assign bus.RegW      = reg_w;
  assign bus.MemW      = mem_w;
  assign bus.ALUSrcA   = alu_src_a;
  assign bus.ALUSrcB   = alu_src_b;
  assign bus.ALUOp     = alu_op;
  assign bus.ResultSrc = result_src;
  assign bus.InstrDone = instr_done;
  assign bus.Undef     = undef;
  assign bus.State     = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle expected state/strobes are queued per instruction
// and compared each cycle at the falling edge.
module tb_multicycle_ctrl;

  logic CLK;
  logic RESETn;

  multicycle_ctrl_if #(.STATE_W(4)) bus ();

  multicycle_ctrl #(.STATE_W(4)) dut (
    .CLK    (CLK),
    .RESETn (RESETn),
    .bus    (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0]  st;
    logic        ready;
    logic [13:0] ctl;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // ctl order: MemReq AdrSrc IRWrite PCWrite RegW MemW ALUSrcA ALUSrcB ALUOp ResultSrc InstrDone Undef
  function automatic logic [13:0] ctl_of(logic mreq, logic adr, logic irw, logic pcw, logic regw,
                                         logic memw, logic asa, logic [1:0] asb, logic aop,
                                         logic [1:0] rs, logic done, logic und);
    return {mreq, adr, irw, pcw, regw, memw, asa, asb, aop, rs, done, und};
  endfunction

  function automatic logic [13:0] obs_ctl();
    return {bus.MemReq, bus.AdrSrc, bus.IRWrite, bus.PCWrite, bus.RegW, bus.MemW, bus.ALUSrcA,
            bus.ALUSrcB, bus.ALUOp, bus.ResultSrc, bus.InstrDone, bus.Undef};
  endfunction

  function automatic exp_t mk(logic [3:0] st, logic rdy, logic [13:0] ctl);
    exp_t e;
    e.st = st; e.ready = rdy; e.ctl = ctl;
    return e;
  endfunction

  task automatic push_instr(input logic [1:0] op, input logic [5:0] funct, input logic [3:0] rd,
                            input logic nw, input logic cx, input int fwait);
    logic w;
    bus.Op = op; bus.Funct = funct; bus.Rd = rd; bus.NoWrite = nw; bus.CondEx = cx;
    for (int i = 0; i < fwait; i++)
      sb.push_back(mk(4'd0, 1'b0, ctl_of(1,0,0,0,0,0,1,2'b10,0,2'b10,0,0)));
    sb.push_back(mk(4'd0, 1'b1, ctl_of(1,0,1,1,0,0,1,2'b10,0,2'b10,0,0)));
    sb.push_back(mk(4'd1, 1'b1, ctl_of(0,0,0,0,0,0,1,2'b10,0,2'b10,op==2'b11,op==2'b11)));
    case (op)
      2'b01: begin
        sb.push_back(mk(4'd2, 1'b1, ctl_of(0,0,0,0,0,0,0,2'b01,0,2'b00,0,0)));
        if (funct[0]) begin
          w = cx;
          sb.push_back(mk(4'd3, 1'b1, ctl_of(1,1,0,0,0,0,0,2'b00,0,2'b00,0,0)));
          sb.push_back(mk(4'd4, 1'b1, ctl_of(0,0,0,w && rd==4'hF,w && rd!=4'hF,0,0,2'b00,0,2'b01,1,0)));
        end else begin
          sb.push_back(mk(4'd5, 1'b1, ctl_of(1,1,0,0,0,cx,0,2'b00,0,2'b00,1,0)));
        end
      end
      2'b00: begin
        w = cx & ~nw;
        if (funct[5]) sb.push_back(mk(4'd7, 1'b1, ctl_of(0,0,0,0,0,0,0,2'b01,1,2'b00,0,0)));
        else          sb.push_back(mk(4'd6, 1'b1, ctl_of(0,0,0,0,0,0,0,2'b00,1,2'b00,0,0)));
        sb.push_back(mk(4'd8, 1'b1, ctl_of(0,0,0,w && rd==4'hF,w && rd!=4'hF,0,0,2'b00,0,2'b00,1,0)));
      end
      2'b10: sb.push_back(mk(4'd9, 1'b1, ctl_of(0,0,0,cx,0,0,0,2'b01,0,2'b10,1,0)));
      default: ;
    endcase
  endtask

  // Each step begins 1 time unit after a rising edge and ends at the same point one cycle later.
  task automatic run_q(input string tag, input int limit);
    exp_t e;
    int   n = 0;
    while (sb.size() > 0 && n < limit) begin
      e = sb.pop_front();
`ifdef MEM_WAIT_EN
      bus.MemReady = e.ready;
`endif
      @(negedge CLK);
      chk({tag, ".state"}, 32'(bus.State), 32'(e.st));
      chk({tag, ".ctl"}, 32'(obs_ctl()), 32'(e.ctl));
      n++;
      @(posedge CLK);
      #1;
    end
`ifdef MEM_WAIT_EN
    bus.MemReady = 1'b1;
`endif
  endtask

  task automatic do_instr(input string tag, input logic [1:0] op, input logic [5:0] funct,
                          input logic [3:0] rd, input logic nw, input logic cx, input int fwait);
    push_instr(op, funct, rd, nw, cx, fwait);
    run_q(tag, 20);
    sb.delete();
  endtask

  localparam logic [13:0] RST_CTL = 14'b0000_0010_0010_00 | 14'b0000_0011_0000_00;

  initial begin
    logic [1:0] rop;
    logic [5:0] rfn;
    RESETn = 1'b0;
    bus.Op = 2'b00; bus.Funct = 6'd0; bus.Rd = 4'd0; bus.NoWrite = 1'b0; bus.CondEx = 1'b0;
`ifdef MEM_WAIT_EN
    bus.MemReady = 1'b1;
`endif
    repeat (2) begin
      @(negedge CLK);
      chk("rst.state", 32'(bus.State), 32'd0);
      chk("rst.ctl", 32'(obs_ctl()), 32'(ctl_of(0,0,0,0,0,0,1,2'b10,0,2'b10,0,0)));
    end
    @(posedge CLK);
    #1 RESETn = 1'b1;

    do_instr("addi",     2'b00, 6'b001000, 4'd3,  1'b0, 1'b1, 0);
    do_instr("ldr_pc",   2'b01, 6'b011001, 4'd15, 1'b0, 1'b1, 0);
    do_instr("str_nc",   2'b01, 6'b011000, 4'd2,  1'b0, 1'b0, 0);
    do_instr("b_taken",  2'b10, 6'b000000, 4'd0,  1'b0, 1'b1, 0);
    do_instr("b_nt",     2'b10, 6'b000000, 4'd0,  1'b0, 1'b0, 0);
    do_instr("cmp",      2'b00, 6'b010101, 4'd0,  1'b1, 1'b1, 0);
    do_instr("undef",    2'b11, 6'b000000, 4'd0,  1'b0, 1'b1, 0);
    do_instr("str_c",    2'b01, 6'b011000, 4'd4,  1'b0, 1'b1, 0);
    do_instr("ldr_nc",   2'b01, 6'b011001, 4'd5,  1'b1, 1'b0, 0);
    do_instr("ldr_nw",   2'b01, 6'b011001, 4'd6,  1'b1, 1'b1, 0);
    do_instr("add_pc",   2'b00, 6'b001000, 4'd15, 1'b0, 1'b1, 0);
    do_instr("and_nc",   2'b00, 6'b000000, 4'd7,  1'b0, 1'b0, 0);

    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom_range(0, 3));
      rfn = 6'($urandom);
      do_instr("rand", rop, rfn, 4'($urandom), 1'($urandom), 1'($urandom), 0);
    end

`ifdef MEM_WAIT_EN
    do_instr("fwait",    2'b00, 6'b001000, 4'd3,  1'b0, 1'b1, 3);
    do_instr("fwait_b",  2'b10, 6'b000000, 4'd0,  1'b0, 1'b1, 1);
`endif

    // Abort a load in MEMRD with an asynchronous reset
    push_instr(2'b01, 6'b011001, 4'd9, 1'b0, 1'b1, 0);
    run_q("abort", 3);
    sb.delete();
    chk("abort.pre_state", 32'(bus.State), 32'd3);
    chk("abort.pre_ctl", 32'(obs_ctl()), 32'(ctl_of(1,1,0,0,0,0,0,2'b00,0,2'b00,0,0)));
    #1 RESETn = 1'b0;
    #1;
    chk("abort.state", 32'(bus.State), 32'd0);
    chk("abort.ctl", 32'(obs_ctl()), 32'(ctl_of(0,0,0,0,0,0,1,2'b10,0,2'b10,0,0)));
    @(posedge CLK);
    #1;
    chk("abort.hold_state", 32'(bus.State), 32'd0);
    chk("abort.hold_ctl", 32'(obs_ctl()), 32'(ctl_of(0,0,0,0,0,0,1,2'b10,0,2'b10,0,0)));
    RESETn = 1'b1;
    do_instr("post_rst", 2'b01, 6'b011001, 4'd1,  1'b0, 1'b1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main control FSM for the multicycle ARMv3 core. Sequences shared datapath resources across several cycles per instruction: one memory port, one ALU, PC/IR/register-file write strobes.
- Inputs: instruction fields from the IR, plus CondEx from the condition-check logic.
- Outputs: per-cycle mux selects and write enables.
- Supports DP register, DP immediate, LDR/STR (immediate offset) and B.

Parameters:
- STATE_W, 4, width of the state register; must be 4 or more.

Ports:
- CLK  in  1  system clock, rising edge
- RESETn  in  1  asynchronous active-low reset
- Op  in  2  instr[27:26] from IR
- Funct  in  6  instr[25:20] from IR
- Rd  in  4  instr[15:12] from IR
- NoWrite  in  1  compare-class DP instruction; suppresses register writeback
- CondEx  in  1  condition passed; sampled only in write-capable states
- MemReady  in  1  memory access completes this cycle; present only with MEM_WAIT_EN
- MemReq  out  1  memory access requested this cycle
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUResult register
- IRWrite  out  1  load IR
- PCWrite  out  1  load PC
- RegW  out  1  register-file write enable
- MemW  out  1  data-memory write enable
- ALUSrcA  out  1  ALU operand A select: 0 = register A, 1 = PC
- ALUSrcB  out  2  ALU operand B select: 00 = register B, 01 = extended immediate, 10 = constant 4
- ALUOp  out  1  1 = ALU operation decoded from Funct, 0 = ADD
- ResultSrc  out  2  result bus select: 00 = ALUOut, 01 = read data, 10 = ALU direct
- InstrDone  out  1  one-cycle pulse on the final cycle of each instruction
- Undef  out  1  one-cycle pulse when Op=11 is decoded
- State  out  STATE_W  current state, for debug

Behaviour:
- State register, asynchronous reset. RESETn low forces state FETCH.
- While RESETn is low, all write strobes are 0: PCWrite, IRWrite, RegW, MemW, MemReq, InstrDone, Undef. The other outputs take their FETCH values.
- All outputs are combinational from state and inputs (Moore outputs, plus CondEx/Rd/NoWrite gating).
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9. Codes 10-15 are illegal and go to FETCH on the next clock.
- Transitions:
  - FETCH -> DECODE.
  - DECODE:
    - Op=01 -> MEMADR.
    - Op=00 with Funct[5]=0 -> EXECR.
    - Op=00 with Funct[5]=1 -> EXECI.
    - Op=10 -> BRANCH.
    - Op=11 -> FETCH, with Undef=1 and InstrDone=1 in that DECODE cycle.
  - MEMADR: Funct[0]=1 -> MEMRD, else -> MEMWR.
  - MEMRD -> MEMWB -> FETCH.
  - MEMWR -> FETCH.
  - EXECR and EXECI -> ALUWB -> FETCH.
  - BRANCH -> FETCH.
- Outputs per state (any output not listed is 0):
  - FETCH: MemReq=1, IRWrite=1, PCWrite=1, ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10. Computes PC+8; no write strobes.
  - MEMADR: ALUSrcB=01.
  - MEMRD: MemReq=1, AdrSrc=1.
  - MEMWB: ResultSrc=01, InstrDone=1.
  - MEMWR: MemReq=1, AdrSrc=1, MemW=CondEx, InstrDone=1.
  - EXECR: ALUOp=1, ALUSrcB=00.
  - EXECI: ALUOp=1, ALUSrcB=01.
  - ALUWB: ResultSrc=00, InstrDone=1.
  - BRANCH: ALUSrcB=01, ResultSrc=10, PCWrite=CondEx, InstrDone=1.
- Writeback gating in MEMWB and ALUWB, with W = CondEx & ~NoWrite:
  - If Rd=4'hF: PCWrite=W and RegW=0.
  - Otherwise: RegW=W and PCWrite=0.
  - NoWrite is treated as 0 in MEMWB.
- A failed condition still walks the full state path. Only the strobes are suppressed.
- Latency without wait states:
  - LDR: 5 cycles.
  - STR: 4 cycles.
  - DP: 4 cycles.
  - B: 3 cycles.
  - Undefined: 2 cycles.
- RESETn asserted mid-instruction aborts it immediately. No partial writes occur after the reset edge.

Optional Feature:
- Macro: MEM_WAIT_EN.
- Defined:
  - The MemReady port exists.
  - FETCH, MEMRD and MEMWR hold their state while MemReady=0, with MemReq held high.
  - IRWrite and PCWrite in FETCH, MemW in MEMWR, and InstrDone in MEMWR assert only in the cycle where MemReady=1.
  - MemReady is ignored in all other states.
- Undefined:
  - No MemReady port.
  - Memory is single-cycle; these states always last exactly 1 cycle.

Test Plan:
- Reset release, Op=00, Funct=6'b001000 (ADD immediate), Rd=3, CondEx=1 -> states 0,1,7,8,0. RegW=1 only in ALUWB; InstrDone pulses once.
- Op=01, Funct[0]=1 (LDR), Rd=15, CondEx=1 -> states 0,1,2,3,4,0. PCWrite=1 and RegW=0 in MEMWB; AdrSrc=1 in MEMRD.
- Op=01, Funct[0]=0 (STR), CondEx=0 -> states 0,1,2,5,0. MemW stays 0 throughout; InstrDone=1 in MEMWR.
- Op=10 (B), CondEx=1, then repeat with CondEx=0 -> PCWrite=1 in BRANCH for the first, 0 for the second; both take 3 cycles.
- Op=00, Funct=6'b010101 (CMP register), NoWrite=1 -> states 0,1,6,8,0 with RegW=0. Then Op=11 -> Undef pulse in DECODE, back to FETCH.
- With MEM_WAIT_EN: MemReady low for 3 cycles during FETCH -> state stays 0 for 4 cycles, IRWrite high in the 4th only. Assert RESETn=0 during MEMRD -> State=0 asynchronously, all strobes 0.
